// File: rtl/spi_time_sync.sv
// PIC->FPGA time link: synchronised SPI frame capture, validation and a 1 Hz time-of-day counter.
// Define DATE_ROLLOVER_EN to advance day/month/year at midnight and range-check day per month.
module spi_time_sync #(
   parameter int unsigned CLK_HZ      = 25_000_000,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       sclk_i,
   input  logic       sdi_i,
   input  logic       cs_n_i,
   output logic [4:0] hour_o,
   output logic [5:0] minute_o,
   output logic [5:0] second_o,
   output logic [3:0] month_o,
   output logic [4:0] day_o,
   output logic [5:0] year_o,
   output logic       time_valid_o,
   output logic       frame_ok_o,
   output logic       frame_err_o
);

   localparam int unsigned DivW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [DivW-1:0] DivMax = DivW'(CLK_HZ - 1);

   typedef enum logic [1:0] {StIdle, StShift, StCheck, StLoad} state_e;

   logic [SYNC_STAGES-1:0] sclk_sync_q, sdi_sync_q, cs_sync_q;
   logic                   sclk_prev_q, cs_prev_q;
   logic                   sclk_s, sdi_s, cs_s;
   logic                   sclk_rise, cs_fall, cs_rise;

   state_e          state_q;
   logic [5:0]      bitcnt_q;
   logic [31:0]     shreg_q;
   logic [DivW-1:0] div_q;
   logic [4:0]      hour_q, day_q;
   logic [5:0]      minute_q, second_q, year_q;
   logic [3:0]      month_q;
   logic            time_valid_q, frame_ok_q, frame_err_q;

   logic [4:0] hour_inc, day_inc;
   logic [5:0] minute_inc, second_inc, year_inc;
   logic [3:0] month_inc;
   logic       frame_in_range;

   // cs_n synchroniser resets high so a deasserted link does not look like a frame start.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sclk_sync_q <= '0;
         sdi_sync_q  <= '0;
         cs_sync_q   <= '1;
         sclk_prev_q <= 1'b0;
         cs_prev_q   <= 1'b1;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
         sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0], sdi_i};
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n_i};
         sclk_prev_q <= sclk_s;
         cs_prev_q   <= cs_s;
      end
   end

   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign sdi_s     = sdi_sync_q[SYNC_STAGES-1];
   assign cs_s      = cs_sync_q[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_prev_q;
   assign cs_fall   = ~cs_s & cs_prev_q;
   assign cs_rise   = cs_s & ~cs_prev_q;

`ifdef DATE_ROLLOVER_EN
   function automatic logic [4:0] month_days(input logic [3:0] mo, input logic [5:0] yr);
      case (mo)
         4'd2:                    return (yr[1:0] == 2'b00) ? 5'd29 : 5'd28;
         4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
         default:                 return 5'd31;
      endcase
   endfunction
`endif

   always_comb begin
      frame_in_range = (shreg_q[31:27] <= 5'd23) && (shreg_q[26:21] <= 6'd59) &&
                       (shreg_q[20:15] <= 6'd59) && (shreg_q[14:11] >= 4'd1) &&
                       (shreg_q[14:11] <= 4'd12) && (shreg_q[10:6] >= 5'd1) &&
                       (shreg_q[10:6] <= 5'd31);
`ifdef DATE_ROLLOVER_EN
      frame_in_range = frame_in_range && (shreg_q[10:6] <= month_days(shreg_q[14:11], shreg_q[5:0]));
`endif
   end

   // Time-of-day after one second, applied only on the divider terminal count.
   always_comb begin
      hour_inc   = hour_q;
      minute_inc = minute_q;
      second_inc = second_q;
      day_inc    = day_q;
      month_inc  = month_q;
      year_inc   = year_q;
      if (second_q != 6'd59) begin
         second_inc = second_q + 6'd1;
      end else begin
         second_inc = 6'd0;
         if (minute_q != 6'd59) begin
            minute_inc = minute_q + 6'd1;
         end else begin
            minute_inc = 6'd0;
            if (hour_q != 5'd23) begin
               hour_inc = hour_q + 5'd1;
            end else begin
               hour_inc = 5'd0;
`ifdef DATE_ROLLOVER_EN
               if (day_q < month_days(month_q, year_q)) begin
                  day_inc = day_q + 5'd1;
               end else begin
                  day_inc = 5'd1;
                  if (month_q < 4'd12) begin
                     month_inc = month_q + 4'd1;
                  end else begin
                     month_inc = 4'd1;
                     year_inc  = year_q + 6'd1;
                  end
               end
`endif
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= StIdle;
         bitcnt_q     <= 6'd0;
         shreg_q      <= 32'd0;
         div_q        <= '0;
         hour_q       <= 5'd0;
         minute_q     <= 6'd0;
         second_q     <= 6'd0;
         month_q      <= 4'd1;
         day_q        <= 5'd1;
         year_q       <= 6'd0;
         time_valid_q <= 1'b0;
         frame_ok_q   <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         frame_ok_q  <= 1'b0;
         frame_err_q <= 1'b0;

         // A load overrides a coincident tick and restarts the second.
         if (state_q == StLoad) begin
            hour_q       <= shreg_q[31:27];
            minute_q     <= shreg_q[26:21];
            second_q     <= shreg_q[20:15];
            month_q      <= shreg_q[14:11];
            day_q        <= shreg_q[10:6];
            year_q       <= shreg_q[5:0];
            div_q        <= '0;
            time_valid_q <= 1'b1;
            frame_ok_q   <= 1'b1;
         end else if (div_q == DivMax) begin
            div_q    <= '0;
            hour_q   <= hour_inc;
            minute_q <= minute_inc;
            second_q <= second_inc;
            month_q  <= month_inc;
            day_q    <= day_inc;
            year_q   <= year_inc;
         end else begin
            div_q <= div_q + DivW'(1);
         end

         case (state_q)
            StIdle: begin
               if (cs_fall) begin
                  state_q  <= StShift;
                  bitcnt_q <= 6'd0;
               end
            end
            StShift: begin
               if (cs_rise) begin
                  if (bitcnt_q == 6'd32) begin
                     state_q <= StCheck;
                  end else begin
                     frame_err_q <= 1'b1;
                     state_q     <= StIdle;
                  end
               end else if (sclk_rise) begin
                  shreg_q <= {shreg_q[30:0], sdi_s};
                  if (bitcnt_q != 6'd33) bitcnt_q <= bitcnt_q + 6'd1;
               end
            end
            StCheck: begin
               if (frame_in_range) begin
                  state_q <= StLoad;
               end else begin
                  frame_err_q <= 1'b1;
                  state_q     <= StIdle;
               end
            end
            StLoad:  state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

   assign hour_o       = hour_q;
   assign minute_o     = minute_q;
   assign second_o     = second_q;
   assign month_o      = month_q;
   assign day_o        = day_q;
   assign year_o       = year_q;
   assign time_valid_o = time_valid_q;
   assign frame_ok_o   = frame_ok_q;
   assign frame_err_o  = frame_err_q;

endmodule

// File: tb/tb_spi_time_sync.sv
// Randomised bench for spi_time_sync with a seconds-of-day reference model (CLK_HZ = 8).
module tb_spi_time_sync;

   localparam int unsigned ClkHz = 8;

   logic       clk, rst_n, sclk, sdi, cs_n;
   logic [4:0] hour, day;
   logic [5:0] minute, second, year;
   logic [3:0] month;
   logic       time_valid, frame_ok, frame_err;

   spi_time_sync #(.CLK_HZ(ClkHz), .SYNC_STAGES(2)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .sclk_i      (sclk),
      .sdi_i       (sdi),
      .cs_n_i      (cs_n),
      .hour_o      (hour),
      .minute_o    (minute),
      .second_o    (second),
      .month_o     (month),
      .day_o       (day),
      .year_o      (year),
      .time_valid_o(time_valid),
      .frame_ok_o  (frame_ok),
      .frame_err_o (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   // Reference model: time as seconds since midnight plus a calendar date.
   int          m_sod, m_day, m_mon, m_year, m_valid, m_div;
   int          ok_cnt = 0, err_cnt = 0;
   logic [31:0] pend;

   function automatic int dim(input int mo, input int yr);
      case (mo)
         2:            return (yr % 4 == 0) ? 29 : 28;
         4, 6, 9, 11:  return 30;
         default:      return 31;
      endcase
   endfunction

   function automatic bit frame_good(input logic [31:0] f);
      int h, mi, s, mo, d, y;
      bit good;
      h = int'(f[31:27]); mi = int'(f[26:21]); s = int'(f[20:15]);
      mo = int'(f[14:11]); d = int'(f[10:6]); y = int'(f[5:0]);
      good = (h <= 23) && (mi <= 59) && (s <= 59) && (mo >= 1) && (mo <= 12) &&
             (d >= 1) && (d <= 31);
`ifdef DATE_ROLLOVER_EN
      good = good && (d <= dim(mo, y));
`endif
      return good;
   endfunction

   function automatic logic [31:0] mk(input int h, input int mi, input int s, input int mo,
                                      input int d, input int y);
      return {h[4:0], mi[5:0], s[5:0], mo[3:0], d[4:0], y[5:0]};
   endfunction

   // One model step per clock, evaluated on the falling edge after each rising edge.
   always @(negedge clk) begin
      if (frame_ok) ok_cnt++;
      if (frame_err) err_cnt++;
      if (!rst_n) begin
         m_sod = 0; m_day = 1; m_mon = 1; m_year = 0; m_valid = 0; m_div = 0;
      end else if (frame_ok) begin
         m_sod   = int'(pend[31:27]) * 3600 + int'(pend[26:21]) * 60 + int'(pend[20:15]);
         m_mon   = int'(pend[14:11]);
         m_day   = int'(pend[10:6]);
         m_year  = int'(pend[5:0]);
         m_valid = 1;
         m_div   = 0;
      end else begin
         m_div++;
         if (m_div == ClkHz) begin
            m_div = 0;
            m_sod++;
            if (m_sod == 86400) begin
               m_sod = 0;
`ifdef DATE_ROLLOVER_EN
               m_day++;
               if (m_day > dim(m_mon, m_year)) begin
                  m_day = 1;
                  m_mon++;
                  if (m_mon > 12) begin
                     m_mon  = 1;
                     m_year = (m_year + 1) % 64;
                  end
               end
`endif
            end
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
      #2;
   endtask

   task automatic compare_all(input string tag);
      check_eq({tag, ".hour"}, int'(hour), m_sod / 3600);
      check_eq({tag, ".minute"}, int'(minute), (m_sod / 60) % 60);
      check_eq({tag, ".second"}, int'(second), m_sod % 60);
      check_eq({tag, ".month"}, int'(month), m_mon);
      check_eq({tag, ".day"}, int'(day), m_day);
      check_eq({tag, ".year"}, int'(year), m_year);
      check_eq({tag, ".valid"}, int'(time_valid), m_valid);
   endtask

   task automatic shift_bits(input logic [63:0] data, input int nbits, input int half);
      for (int i = 0; i < nbits; i++) begin
         sdi = data[nbits - 1 - i];
         cyc(half);
         sclk = 1'b1;
         cyc(half);
         sclk = 1'b0;
      end
   endtask

   task automatic send_frame(input string tag, input logic [63:0] data, input int nbits,
                             input int half);
      int ok0, err0;
      bit exp_ok;
      exp_ok = (nbits == 32) && frame_good(data[31:0]);
      pend   = data[31:0];
      ok0    = ok_cnt;
      err0   = err_cnt;
      cs_n   = 1'b0;
      cyc(3);
      shift_bits(data, nbits, half);
      cyc(2);
      cs_n = 1'b1;
      for (int k = 0; k < 15 && ok_cnt == ok0 && err_cnt == err0; k++) cyc(1);
      cyc(3);
      check_eq({tag, ".ok_pulses"}, ok_cnt - ok0, exp_ok ? 1 : 0);
      check_eq({tag, ".err_pulses"}, err_cnt - err0, exp_ok ? 0 : 1);
      compare_all(tag);
   endtask

   task automatic idle_toggle(input int n);
      for (int i = 0; i < n; i++) begin
         sclk = 1'b1; sdi = 1'($urandom);
         cyc(3);
         sclk = 1'b0;
         cyc(3);
      end
   endtask

   initial begin
      int          ok0, err0, kind, mo, y, d;
      logic [63:0] f;
      rst_n = 1'b1; cs_n = 1'b1; sclk = 1'b0; sdi = 1'b0;
      #1 rst_n = 1'b0;

      // Reset values and quiet pulses
      cyc(3);
      check_eq("rst.hour", int'(hour), 0);
      check_eq("rst.month", int'(month), 1);
      check_eq("rst.day", int'(day), 1);
      check_eq("rst.valid", int'(time_valid), 0);
      check_eq("rst.pulses", ok_cnt + err_cnt, 0);
      rst_n = 1'b1;
      cyc(5);
      compare_all("post_rst");

      // sclk activity with cs_n high must do nothing
      idle_toggle(4);
      check_eq("idle_sclk.pulses", ok_cnt + err_cnt, 0);
      compare_all("idle_sclk");

      // Known frame
      send_frame("known", 64'h6DAF508E, 32, 4);
      check_eq("known.hour_c", int'(hour), 13);
      check_eq("known.min_c", int'(minute), 45);
      check_eq("known.sec_c", int'(second), 30);
      check_eq("known.mon_c", int'(month), 10);
      check_eq("known.day_c", int'(day), 2);
      check_eq("known.year_c", int'(year), 14);

      // Length and range errors
      send_frame("len31", 64'h36D7A847, 31, 3);
      send_frame("len33", 64'h1_2345_6789, 33, 3);
      send_frame("hour24", {32'd0, mk(24, 0, 0, 1, 1, 0)}, 32, 3);
      send_frame("month0", {32'd0, mk(5, 0, 0, 0, 1, 0)}, 32, 3);

      // End-of-year rollover
      send_frame("eoy", {32'd0, mk(23, 59, 59, 12, 31, 63)}, 32, 3);
      cyc(8);
      compare_all("eoy_tick");
      check_eq("eoy_tick.hour_c", int'(hour), 0);
      check_eq("eoy_tick.sec_c", int'(second), 0);
`ifdef DATE_ROLLOVER_EN
      check_eq("eoy_tick.month_c", int'(month), 1);
      check_eq("eoy_tick.year_c", int'(year), 0);
`else
      check_eq("eoy_tick.month_c", int'(month), 12);
      check_eq("eoy_tick.year_c", int'(year), 63);
`endif
      send_frame("feb30", {32'd0, mk(1, 2, 3, 2, 30, 5)}, 32, 3);

      // Reset mid-frame, then a clean frame
      cs_n = 1'b0;
      cyc(3);
      shift_bits(64'h0000_0000_0000_ABCD, 16, 3);
      rst_n = 1'b0;
      cyc(2);
      check_eq("midrst.hour", int'(hour), 0);
      check_eq("midrst.day", int'(day), 1);
      check_eq("midrst.valid", int'(time_valid), 0);
      cs_n  = 1'b1;
      rst_n = 1'b1;
      cyc(3);
      compare_all("midrst");
      send_frame("after_rst", {32'd0, mk(7, 8, 9, 3, 4, 25)}, 32, 4);

      // Randomised frames, including near-rollover loads
      for (int it = 0; it < 24; it++) begin
         kind = int'($urandom_range(0, 3));
         mo   = int'($urandom_range(1, 12));
         y    = int'($urandom_range(0, 63));
         d    = int'($urandom_range(1, dim(mo, y)));
         if (kind == 0)
            f = {32'd0, mk(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)),
                           int'($urandom_range(0, 59)), mo, d, y)};
         else if (kind == 1)
            f = {32'd0, mk(23, 59, int'($urandom_range(50, 59)), mo, dim(mo, y), y)};
         else
            f = {$urandom, $urandom};
         send_frame($sformatf("rnd%0d", it), f, (kind == 2) ? (($urandom % 2) ? 31 : 33) : 32,
                    int'($urandom_range(3, 5)));
         ok0  = ok_cnt;
         err0 = err_cnt;
         idle_toggle(int'($urandom_range(0, 3)));
         cyc(int'($urandom_range(0, 40)));
         check_eq($sformatf("rnd%0d.idle_pulses", it), ok_cnt + err_cnt - ok0 - err0, 0);
         compare_all($sformatf("rnd%0d.idle", it));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
